// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared states, vector count and response-bit indices for the gate test sequencer
package gate_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int RESP_W      = 6;

  // Response vector order is {yor, yand, ynand, yxor, ynot, ynor}, msb first
  localparam int IDX_YOR   = 5;
  localparam int IDX_YAND  = 4;
  localparam int IDX_YNAND = 3;
  localparam int IDX_YXOR  = 2;
  localparam int IDX_YNOT  = 1;
  localparam int IDX_YNOR  = 0;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden responses for one a/b/c stimulus vector
module gate_ref_model (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic yor,
  output logic yand,
  output logic ynand,
  output logic yxor,
  output logic ynot,
  output logic ynor
);

  assign yor   = a | b;
  assign yand  = a & b;
  assign ynand = ~(a & b);
  assign yxor  = a ^ b;
  assign ynot  = ~c;
  assign ynor  = ~(a | b);

endmodule

// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - walks all 8 a/b/c vectors through a gate block and counts failing vectors
// Optional first-failure log enabled by macro GATE_SEQ_FAIL_LOG_EN.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       yor,
  input  logic       yand,
  input  logic       ynand,
  input  logic       yxor,
  input  logic       ynot,
  input  logic       ynor,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
`ifdef GATE_SEQ_FAIL_LOG_EN
  output logic       fail_valid,
  output logic [2:0] first_fail_vec,
  output logic [5:0] first_fail_mask,
`endif
  output logic [2:0] vec_idx
);

  state_t      state, state_nxt;
  logic [3:0]  settle_cnt, settle_cnt_nxt;
  logic [2:0]  vec_nxt;
  logic [3:0]  err_nxt;
  logic        a_nxt, b_nxt, c_nxt;
  logic        run_start;
  logic        vec_fail;
  logic [RESP_W-1:0] exp_resp, got_resp, mismatch;
  logic        e_or, e_and, e_nand, e_xor, e_not, e_nor;

  gate_ref_model u_ref (
    .a     (a),
    .b     (b),
    .c     (c),
    .yor   (e_or),
    .yand  (e_and),
    .ynand (e_nand),
    .yxor  (e_xor),
    .ynot  (e_not),
    .ynor  (e_nor)
  );

  always_comb begin
    exp_resp = '0;
    got_resp = '0;
    exp_resp[IDX_YOR]   = e_or;
    exp_resp[IDX_YAND]  = e_and;
    exp_resp[IDX_YNAND] = e_nand;
    exp_resp[IDX_YXOR]  = e_xor;
    exp_resp[IDX_YNOT]  = e_not;
    exp_resp[IDX_YNOR]  = e_nor;
    got_resp[IDX_YOR]   = yor;
    got_resp[IDX_YAND]  = yand;
    got_resp[IDX_YNAND] = ynand;
    got_resp[IDX_YXOR]  = yxor;
    got_resp[IDX_YNOT]  = ynot;
    got_resp[IDX_YNOR]  = ynor;
  end

  assign mismatch = exp_resp ^ got_resp;
  assign vec_fail = |mismatch;

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    vec_nxt        = vec_idx;
    err_nxt        = err_count;
    a_nxt          = a;
    b_nxt          = b;
    c_nxt          = c;
    run_start      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_DRIVE;
          vec_nxt   = '0;
          err_nxt   = '0;
          run_start = 1'b1;
        end
      end
      ST_DRIVE: begin
        a_nxt          = vec_idx[2];
        b_nxt          = vec_idx[1];
        c_nxt          = vec_idx[0];
        settle_cnt_nxt = 4'(SETTLE_CYCLES);
        state_nxt      = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The loaded count is consumed one per cycle, so SETTLE lasts exactly SETTLE_CYCLES cycles
        if (settle_cnt <= 4'd1) begin
          settle_cnt_nxt = '0;
          state_nxt      = ST_CHECK;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      ST_CHECK: begin
        if (vec_fail) err_nxt = err_count + 4'd1;
        if (vec_idx == 3'(NUM_VECTORS - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          vec_nxt   = vec_idx + 3'd1;
          state_nxt = ST_DRIVE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      vec_idx    <= '0;
      err_count  <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      c          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_cnt_nxt;
      vec_idx    <= vec_nxt;
      err_count  <= err_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      c          <= c_nxt;
      busy       <= (state_nxt == ST_DRIVE) || (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
      done       <= (state_nxt == ST_DONE);
      pass       <= (state_nxt == ST_DONE) && (err_nxt == 4'd0);
    end
  end

`ifdef GATE_SEQ_FAIL_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_valid      <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else if (run_start) begin
      fail_valid      <= 1'b0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else if (state == ST_CHECK && vec_fail && !fail_valid) begin
      fail_valid      <= 1'b1;
      first_fail_vec  <= vec_idx;
      first_fail_mask <= mismatch;
    end
  end
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - randomized and directed self-checking bench for gate_test_sequencer
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       start [2];
  logic       a [2], b [2], c [2];
  logic       busy [2], done [2], pass [2];
  logic [5:0] resp [2];
  logic [3:0] err_count [2];
  logic [2:0] vec_idx [2];
`ifdef GATE_SEQ_FAIL_LOG_EN
  logic       fail_valid [2];
  logic [2:0] first_fail_vec [2];
  logic [5:0] first_fail_mask [2];
`endif

  logic [5:0] stuck_mask, stuck_val;
  logic [5:0] flip [8];
  int checks = 0;
  int passes = 0;

  // Golden truth table from arithmetic on the vector number, bit order {or,and,nand,xor,not,nor}
  function automatic logic [5:0] ideal_resp(input int v);
    int ai, bi, ci;
    logic [5:0] r;
    ai = v / 4; bi = (v / 2) % 2; ci = v % 2;
    r[5] = (ai + bi) > 0;
    r[4] = (ai * bi) == 1;
    r[3] = (ai * bi) == 0;
    r[2] = ((ai + bi) % 2) == 1;
    r[1] = ci == 0;
    r[0] = (ai + bi) == 0;
    return r;
  endfunction

  function automatic logic [5:0] faulty_resp(input int v);
    return ((ideal_resp(v) & ~stuck_mask) | stuck_val) ^ flip[v];
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) resp[i] = faulty_resp(int'({a[i], b[i], c[i]}));
  end

  gate_test_sequencer #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst[0]), .start(start[0]),
    .a(a[0]), .b(b[0]), .c(c[0]),
    .yor(resp[0][5]), .yand(resp[0][4]), .ynand(resp[0][3]),
    .yxor(resp[0][2]), .ynot(resp[0][1]), .ynor(resp[0][0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
`ifdef GATE_SEQ_FAIL_LOG_EN
    .fail_valid(fail_valid[0]), .first_fail_vec(first_fail_vec[0]), .first_fail_mask(first_fail_mask[0]),
`endif
    .vec_idx(vec_idx[0])
  );

  gate_test_sequencer #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst(rst[1]), .start(start[1]),
    .a(a[1]), .b(b[1]), .c(c[1]),
    .yor(resp[1][5]), .yand(resp[1][4]), .ynand(resp[1][3]),
    .yxor(resp[1][2]), .ynot(resp[1][1]), .ynor(resp[1][0]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
`ifdef GATE_SEQ_FAIL_LOG_EN
    .fail_valid(fail_valid[1]), .first_fail_vec(first_fail_vec[1]), .first_fail_mask(first_fail_mask[1]),
`endif
    .vec_idx(vec_idx[1])
  );

  task automatic set_fault(input logic [5:0] m, input logic [5:0] v);
    stuck_mask = m;
    stuck_val  = v;
    for (int i = 0; i < 8; i++) flip[i] = '0;
  endtask

  // Pulse (or hold) start, then count edges after the sampling edge until done is seen; -1 on timeout
  task automatic do_run(input int sel, input bit hold, output int lat, output bit seq_ok);
    logic [2:0] seen [$];
    logic [2:0] cur;
    @(negedge clk); start[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk); if (!hold) start[sel] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      @(negedge clk);
      cur = {a[sel], b[sel], c[sel]};
      if (busy[sel] && (seen.size() == 0 || seen[seen.size()-1] != cur)) seen.push_back(cur);
      if (done[sel]) begin lat = k; break; end
    end
    seq_ok = (seen.size() == 8);
    for (int j = 0; j < seen.size(); j++) if (seen[j] != 3'(j)) seq_ok = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin rst[i] = 1'b1; start[i] = 1'b0; end
    set_fault('0, '0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({a[i], b[i], c[i], busy[i], done[i], pass[i], err_count[i], vec_idx[i]} !== 13'd0)
        $display("FAIL reset_outputs[%0d]: got %b expected all zero", i,
                 {a[i], b[i], c[i], busy[i], done[i], pass[i], err_count[i], vec_idx[i]});
      else passes++;
    end
    for (int i = 0; i < 2; i++) rst[i] = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) $display("FAIL idle_no_start: busy %b%b expected 00", busy[0], busy[1]);
    else passes++;
  endtask

  task automatic test_good_run;
    int lat; bit seq_ok;
    set_fault('0, '0);
    do_run(0, 1'b0, lat, seq_ok);
    checks++; if (lat !== 24) $display("FAIL good_latency: got %0d expected 24", lat); else passes++;
    checks++; if (!seq_ok) $display("FAIL good_abc_sequence: got out-of-order expected 0..7"); else passes++;
    checks++;
    if ({pass[0], err_count[0], busy[0], a[0], b[0], c[0], vec_idx[0]} !== {1'b1, 4'd0, 1'b0, 3'b111, 3'd7})
      $display("FAIL good_done_state: got %b expected %b",
               {pass[0], err_count[0], busy[0], a[0], b[0], c[0], vec_idx[0]}, {1'b1, 4'd0, 1'b0, 3'b111, 3'd7});
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if (done[0] !== 1'b1 || pass[0] !== 1'b1) $display("FAIL done_hold: got done=%b pass=%b expected 1 1", done[0], pass[0]);
    else passes++;
  endtask

  task automatic test_stuck(input string name, input logic [5:0] m, input logic [5:0] v);
    int lat; bit seq_ok; int exp_err; int exp_vec; logic [5:0] exp_mask;
    set_fault(m, v);
    exp_err = 0; exp_vec = -1; exp_mask = '0;
    for (int i = 0; i < 8; i++)
      if (faulty_resp(i) != ideal_resp(i)) begin
        exp_err++;
        if (exp_vec < 0) begin exp_vec = i; exp_mask = faulty_resp(i) ^ ideal_resp(i); end
      end
    do_run(0, 1'b0, lat, seq_ok);
    checks++;
    if (int'(err_count[0]) != exp_err || lat != 24)
      $display("FAIL %s_err_count: got %0d (lat %0d) expected %0d (lat 24)", name, err_count[0], lat, exp_err);
    else passes++;
    checks++; if (pass[0] !== 1'b0) $display("FAIL %s_pass: got %b expected 0", name, pass[0]); else passes++;
`ifdef GATE_SEQ_FAIL_LOG_EN
    checks++;
    if (fail_valid[0] !== 1'b1 || int'(first_fail_vec[0]) != exp_vec || first_fail_mask[0] !== exp_mask)
      $display("FAIL %s_fail_log: got v=%b vec=%0d mask=%b expected 1 %0d %b", name,
               fail_valid[0], first_fail_vec[0], first_fail_mask[0], exp_vec, exp_mask);
    else passes++;
`endif
  endtask

  task automatic test_random;
    int lat; bit seq_ok; int exp_err; int exp_vec; logic [5:0] exp_mask; int sel;
    for (int it = 0; it < 6; it++) begin
      sel = it % 2;
      set_fault('0, '0);
      for (int i = 0; i < 8; i++) flip[i] = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      exp_err = 0; exp_vec = -1; exp_mask = '0;
      for (int i = 0; i < 8; i++)
        if (flip[i] != 0) begin
          exp_err++;
          if (exp_vec < 0) begin exp_vec = i; exp_mask = flip[i]; end
        end
      do_run(sel, 1'b0, lat, seq_ok);
      checks++;
      if (int'(err_count[sel]) != exp_err || pass[sel] !== (exp_err == 0) || lat != 8 * (sel * 2 + 3))
        $display("FAIL random_run%0d: got err=%0d pass=%b lat=%0d expected err=%0d pass=%b lat=%0d", it,
                 err_count[sel], pass[sel], lat, exp_err, exp_err == 0, 8 * (sel * 2 + 3));
      else passes++;
`ifdef GATE_SEQ_FAIL_LOG_EN
      checks++;
      if (fail_valid[sel] !== (exp_err != 0) || (exp_err != 0 &&
          (int'(first_fail_vec[sel]) != exp_vec || first_fail_mask[sel] !== exp_mask)))
        $display("FAIL random_fail_log%0d: got v=%b vec=%0d mask=%b expected %b %0d %b", it,
                 fail_valid[sel], first_fail_vec[sel], first_fail_mask[sel], exp_err != 0, exp_vec, exp_mask);
      else passes++;
`endif
    end
  endtask

  task automatic test_reset_mid_run;
    int lat; bit seq_ok; bit found;
    set_fault(6'b000010, 6'b000000);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (busy[0] && {a[0], b[0], c[0]} == 3'b100) found = 1'b1;
    end
    checks++;
    if (!found || err_count[0] !== 4'd2) $display("FAIL mid_run_reach_vec4: got found=%b err=%0d expected 1 2", found, err_count[0]);
    else passes++;
    rst[0] = 1'b1;
    #1;
    checks++;
    if ({a[0], b[0], c[0], busy[0], done[0], pass[0], err_count[0], vec_idx[0]} !== 13'd0)
      $display("FAIL mid_run_async_reset: got %b expected all zero",
               {a[0], b[0], c[0], busy[0], done[0], pass[0], err_count[0], vec_idx[0]});
    else passes++;
    @(negedge clk); rst[0] = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy[0] !== 1'b0) $display("FAIL post_reset_idle: busy got %b expected 0", busy[0]); else passes++;
    set_fault('0, '0);
    do_run(0, 1'b0, lat, seq_ok);
    checks++;
    if (pass[0] !== 1'b1 || err_count[0] !== 4'd0 || lat != 24 || !seq_ok)
      $display("FAIL post_reset_run: got pass=%b err=%0d lat=%0d expected 1 0 24", pass[0], err_count[0], lat);
    else passes++;
  endtask

  task automatic test_start_held;
    int lat; bit seq_ok; bit got_done;
    set_fault(6'b000010, 6'b000000);
    do_run(0, 1'b1, lat, seq_ok);
    checks++;
    if (lat != 24 || !seq_ok || err_count[0] !== 4'd4)
      $display("FAIL held_start_no_restart: got lat=%0d seq=%b err=%0d expected 24 1 4", lat, seq_ok, err_count[0]);
    else passes++;
    set_fault('0, '0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy[0], done[0], err_count[0]} !== {1'b1, 1'b0, 4'd0})
      $display("FAIL held_start_restart: got busy=%b done=%b err=%0d expected 1 0 0", busy[0], done[0], err_count[0]);
    else passes++;
    start[0] = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 100 && !got_done; k++) begin
      @(negedge clk);
      got_done = done[0];
    end
    checks++;
    if (!got_done || pass[0] !== 1'b1) $display("FAIL held_start_rerun: got done=%b pass=%b expected 1 1", got_done, pass[0]);
    else passes++;
  endtask

  task automatic test_settle3;
    int lat; bit seq_ok;
    set_fault('0, '0);
    do_run(1, 1'b0, lat, seq_ok);
    checks++; if (lat != 40) $display("FAIL settle3_latency: got %0d expected 40", lat); else passes++;
    checks++;
    if (!seq_ok || pass[1] !== 1'b1 || err_count[1] !== 4'd0)
      $display("FAIL settle3_result: got seq=%b pass=%b err=%0d expected 1 1 0", seq_ok, pass[1], err_count[1]);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_good_run();
    test_stuck("ynot_stuck0", 6'b000010, 6'b000000);
    test_stuck("yand_stuck1", 6'b010000, 6'b010000);
    test_reset_mid_run();
    test_start_held();
    test_settle3();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
